rank_order_filter: RTL and testbench

Parametrised, pipelined 3x3 rank-order filter for the image path. It generalises the binary-window majority median filter to multi-bit pixels and a selectable order statistic: min, median, max, or any rank in between. It accepts one 9-pixel window per cycle through a valid/ready handshake and returns the selected rank value a fixed number of cycles later. It sits between the window/line-buffer stage and the downstream pixel sink.

---
 rtl/rank_order_filter.sv | 121 ++++++++++++
 tb/tb_rank_order_filter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rank_order_filter.sv
// rank_order_filter
// Pipelined 3x3 rank-order filter. Nine pixels are captured into S0, fully
// sorted by nine odd-even transposition passes (S1..S9), and the requested
// order statistic is registered into outData. The whole pipeline advances
// in lock-step whenever the output register is empty or being drained.

module rank_order_filter #(
    parameter int PIXEL_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9*PIXEL_W-1:0] windowIn,
    input  logic [3:0]           rank,
    input  logic                 inValid,
    output logic                 inReady,
    output logic [PIXEL_W-1:0]   outData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 busy
);

    // Stage 0 is the capture stage, stages 1..9 hold the result of sort pass n.
    logic [9*PIXEL_W-1:0] data_r  [0:9];
    logic [3:0]           rank_r  [0:9];
    logic [9:0]           valid_r;
    logic [PIXEL_W-1:0]   out_data_r;
    logic                 out_valid_r;

    logic                 adv_s;
    logic [3:0]           rank_clamp_s;
    logic [9*PIXEL_W-1:0] pass_s  [1:9];
    logic [PIXEL_W-1:0]   sel_s;

    // One odd-even transposition pass. Odd passes start at index 0, even
    // passes at index 1; each pair leaves the smaller value at the lower index.
    function automatic logic [9*PIXEL_W-1:0] sort_pass(
        input logic [9*PIXEL_W-1:0] v,
        input logic                 odd_pass
    );
        logic [9*PIXEL_W-1:0] res;
        logic [PIXEL_W-1:0]   lo;
        logic [PIXEL_W-1:0]   hi;
        int                   first;
        res   = v;
        first = odd_pass ? 0 : 1;
        for (int j = 0; j < 4; j++) begin
            lo = v[(first + 2*j) * PIXEL_W +: PIXEL_W];
            hi = v[(first + 2*j + 1) * PIXEL_W +: PIXEL_W];
            if (lo > hi) begin
                res[(first + 2*j) * PIXEL_W +: PIXEL_W]     = hi;
                res[(first + 2*j + 1) * PIXEL_W +: PIXEL_W] = lo;
            end else begin
                res[(first + 2*j) * PIXEL_W +: PIXEL_W]     = lo;
                res[(first + 2*j + 1) * PIXEL_W +: PIXEL_W] = hi;
            end
        end
        return res;
    endfunction

    // Handshake: everything moves together unless a valid output is stuck.
    always_comb begin
        adv_s        = !out_valid_r || outReady;
        rank_clamp_s = (rank > 4'd8) ? 4'd8 : rank;
    end

    // Combinational sort network between stage registers.
    always_comb begin
        for (int p = 1; p <= 9; p++) begin
            pass_s[p] = sort_pass(data_r[p-1], (p % 2) == 1);
        end
    end

    // Pick the requested order statistic from the fully sorted S9 vector.
    always_comb begin
        sel_s = '0;
        case (rank_r[9])
            4'd0:    sel_s = data_r[9][0*PIXEL_W +: PIXEL_W];
            4'd1:    sel_s = data_r[9][1*PIXEL_W +: PIXEL_W];
            4'd2:    sel_s = data_r[9][2*PIXEL_W +: PIXEL_W];
            4'd3:    sel_s = data_r[9][3*PIXEL_W +: PIXEL_W];
            4'd4:    sel_s = data_r[9][4*PIXEL_W +: PIXEL_W];
            4'd5:    sel_s = data_r[9][5*PIXEL_W +: PIXEL_W];
            4'd6:    sel_s = data_r[9][6*PIXEL_W +: PIXEL_W];
            4'd7:    sel_s = data_r[9][7*PIXEL_W +: PIXEL_W];
            default: sel_s = data_r[9][8*PIXEL_W +: PIXEL_W];
        endcase
    end

    // Valid bits and output register; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r     <= 10'd0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (adv_s) begin
            valid_r     <= {valid_r[8:0], inValid};
            out_valid_r <= valid_r[9];
            if (valid_r[9]) begin
                out_data_r <= sel_s;
            end
        end
    end

    // Pixel and rank payload; no reset needed because valid bits gate it.
    always_ff @(posedge clk) begin
        if (adv_s) begin
            data_r[0] <= windowIn;
            rank_r[0] <= rank_clamp_s;
            for (int p = 1; p <= 9; p++) begin
                data_r[p] <= pass_s[p];
                rank_r[p] <= rank_r[p-1];
            end
        end
    end

    assign inReady  = adv_s && !reset;
    assign outData  = out_data_r;
    assign outValid = out_valid_r;
    assign busy     = (|valid_r) || out_valid_r;

endmodule

// File: tb/tb_rank_order_filter.sv
// Directed bench for rank_order_filter: an 8-bit instance for ranks,
// streaming, backpressure and reset, plus a 1-bit instance compared
// against the binary majority rule.

module tb_rank_order_filter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [71:0] win;
    logic [3:0]  rnk;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    logic [8:0]  b_win;
    logic [3:0]  b_rnk;
    logic        b_valid;
    logic        b_in_ready;
    logic [0:0]  b_data;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_busy;

    rank_order_filter #(.PIXEL_W(8)) dut (
        .clk(clk), .reset(reset), .windowIn(win), .rank(rnk),
        .inValid(in_valid), .inReady(in_ready), .outData(out_data),
        .outValid(out_valid), .outReady(out_ready), .busy(busy)
    );

    rank_order_filter #(.PIXEL_W(1)) dut_bin (
        .clk(clk), .reset(reset), .windowIn(b_win), .rank(b_rnk),
        .inValid(b_valid), .inReady(b_in_ready), .outData(b_data),
        .outValid(b_out_valid), .outReady(b_out_ready), .busy(b_busy)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          first_acc, last_acc, first_pop, last_pop, pops, b_pops;
    logic [7:0]  q8 [$];
    logic        q1 [$];
    logic [7:0]  exp_in;
    logic        b_exp_in;
    logic        last_step_acc;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Order-statistic model by counting: p is rank r iff #(<p) <= r < #(<=p).
    function automatic logic [7:0] model_sel(input logic [71:0] w, input int r);
        int         rr, lt, le;
        logic [7:0] p, q, res;
        rr  = (r > 8) ? 8 : r;
        res = 8'd0;
        for (int i = 0; i < 9; i++) begin
            p = w[i*8 +: 8];
            lt = 0;
            le = 0;
            for (int j = 0; j < 9; j++) begin
                q = w[j*8 +: 8];
                if (q < p) lt++;
                if (q <= p) le++;
            end
            if (lt <= rr && rr < le) res = p;
        end
        return res;
    endfunction

    function automatic logic [71:0] mk(input logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8);
        return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    function automatic logic [71:0] rand_win();
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'($urandom_range(0, 255));
        return w;
    endfunction

    // One clock: note handshakes just before the edge, then sample #1 after it.
    task automatic step();
        logic acc, pop, bacc, bpop;
        #1;
        acc  = in_valid && in_ready;
        pop  = out_valid && out_ready && !reset;
        bacc = b_valid && b_in_ready;
        bpop = b_out_valid && b_out_ready && !reset;
        if (pop) begin
            if (q8.size() == 0) check_value("out_without_expect", q8.size(), 32'd1);
            else check_value("out_data", out_data, q8.pop_front());
            pops++;
            if (first_pop < 0) first_pop = cyc + 1;
            last_pop = cyc + 1;
        end
        if (acc) begin
            q8.push_back(exp_in);
            if (first_acc < 0) first_acc = cyc + 1;
            last_acc = cyc + 1;
        end
        if (bpop) begin
            if (q1.size() == 0) check_value("bin_out_without_expect", q1.size(), 32'd1);
            else check_value("bin_out", b_data, q1.pop_front());
            b_pops++;
        end
        if (bacc) q1.push_back(b_exp_in);
        last_step_acc = acc;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            q8.delete();
            q1.delete();
        end
    endtask

    // Single window into an idle pipe: checks latency 10 and the value.
    task automatic send_one(input string tag, input logic [71:0] w, input logic [3:0] r, input logic [7:0] e);
        win = w; rnk = r; exp_in = e; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 9)  check_value({tag, "_early"}, out_valid, 32'd0);
            if (i == 10) check_value({tag, "_k10"}, out_valid, 32'd1);
        end
        step();
    endtask

    logic [71:0] bp_win [15];
    logic [7:0]  hold_d;
    int          sent, stalled, base;
    logic        ov_h [40];

    initial begin
        reset = 1'b1; win = '0; rnk = 4'd0; in_valid = 1'b0; out_ready = 1'b1;
        b_win = '0; b_rnk = 4'd4; b_valid = 1'b0; b_out_ready = 1'b1;
        exp_in = 8'd0; b_exp_in = 1'b0;
        first_acc = -1; first_pop = -1; last_acc = 0; last_pop = 0; pops = 0; b_pops = 0;
        step(); step();
        check_value("rst_out_valid", out_valid, 32'd0);
        check_value("rst_busy", busy, 32'd0);
        check_value("rst_out_data", out_data, 32'd0);
        check_value("rst_in_ready", in_ready, 32'd0);
        reset = 1'b0;
        #1;
        check_value("rel_in_ready", in_ready, 32'd1);

        // Basic ranks and boundaries (hand-computed).
        send_one("med",    mk(9,3,7,1,5,8,2,6,4), 4'd4,  8'd5);
        send_one("min",    mk(9,3,7,1,5,8,2,6,4), 4'd0,  8'd1);
        send_one("max",    mk(9,3,7,1,5,8,2,6,4), 4'd8,  8'd9);
        send_one("rank2",  mk(9,3,7,1,5,8,2,6,4), 4'd2,  8'd3);
        send_one("rank12", mk(9,3,7,1,5,8,2,6,4), 4'd12, 8'd9);
        send_one("ff_r0",  mk(255,255,255,255,255,255,255,255,255), 4'd0, 8'd255);
        send_one("ff_r4",  mk(255,255,255,255,255,255,255,255,255), 4'd4, 8'd255);
        send_one("ff_r8",  mk(255,255,255,255,255,255,255,255,255), 4'd8, 8'd255);
        send_one("alt_r4", mk(0,255,0,255,0,255,0,255,0), 4'd4, 8'd0);
        send_one("alt_r5", mk(0,255,0,255,0,255,0,255,0), 4'd5, 8'd255);

        // Streaming, mixed ranks.
        first_acc = -1; first_pop = -1; pops = 0;
        for (int i = 0; i < 20; i++) begin
            win = rand_win(); rnk = 4'(i % 9); exp_in = model_sel(win, i % 9); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 30 && cyc < last_acc + 10; i++) step();
        check_value("stream_busy_k10", busy, 32'd1);
        step();
        check_value("stream_busy_k11", busy, 32'd0);
        check_value("stream_count", pops, 32'd20);
        check_value("stream_first_lat", first_pop - first_acc, 32'd11);
        check_value("stream_consecutive", last_pop - first_pop, 32'd19);

        // Backpressure while streaming.
        for (int i = 0; i < 15; i++) bp_win[i] = rand_win();
        sent = 0; stalled = 0; pops = 0;
        for (int g = 0; g < 200 && (sent < 15 || q8.size() > 0); g++) begin
            if (sent < 15) begin
                win = bp_win[sent]; rnk = 4'((sent * 4) % 13);
                exp_in = model_sel(bp_win[sent], (sent * 4) % 13); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (stalled < 5 && sent >= 12 && out_valid) begin
                out_ready = 1'b0;
                stalled++;
                hold_d = out_data;
                #1;
                check_value("bp_in_ready", in_ready, 32'd0);
                step();
                check_value("bp_hold_data", out_data, hold_d);
                check_value("bp_hold_valid", out_valid, 32'd1);
            end else begin
                out_ready = 1'b1;
                step();
            end
            if (last_step_acc) sent++;
        end
        out_ready = 1'b1;
        check_value("bp_stalls", stalled, 32'd5);
        check_value("bp_count", pops, 32'd15);

        // Reset with six windows in flight.
        for (int i = 0; i < 6; i++) begin
            win = rand_win(); rnk = 4'd4; exp_in = model_sel(win, 4); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        check_value("mid_rst_out_valid", out_valid, 32'd0);
        check_value("mid_rst_busy", busy, 32'd0);
        check_value("mid_rst_out_data", out_data, 32'd0);
        check_value("mid_rst_in_ready", in_ready, 32'd0);
        reset = 1'b0;
        #1;
        check_value("mid_rel_in_ready", in_ready, 32'd1);
        send_one("post_rst", mk(9,3,7,1,5,8,2,6,4), 4'd4, 8'd5);
        for (int i = 0; i < 12; i++) step();
        check_value("post_rst_drained", q8.size(), 32'd0);
        check_value("post_rst_idle", busy, 32'd0);

        // inValid toggling: outValid is the same pattern ten edges later.
        base = cyc;
        for (int i = 0; i < 40; i++) begin
            win = rand_win(); rnk = 4'(i % 9); exp_in = model_sel(win, i % 9);
            in_valid = ((i < 20) && (i % 2 == 0)) ? 1'b1 : 1'b0;
            step();
            ov_h[i] = out_valid;
        end
        for (int i = 10; i < 40; i++) begin
            check_value("toggle_valid", ov_h[i], ((i - 10 < 20) && ((i - 10) % 2 == 0)) ? 32'd1 : 32'd0);
        end
        check_value("toggle_drained", q8.size(), 32'd0);

        // Binary equivalence on the 1-bit instance.
        b_pops = 0;
        for (int n = 0; n < 512; n++) begin
            b_win = 9'(n);
            b_exp_in = ($countones(9'(n)) >= 5) ? 1'b1 : 1'b0;
            b_valid = 1'b1;
            step();
        end
        b_valid = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check_value("bin_count", b_pops, 32'd512);
        check_value("bin_drained", q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
